// File: rtl/button_event_decoder_pkg.sv
// Shared definitions for the button event decoder: state encoding and timing
// defaults derived from the common board clock.
package button_event_decoder_pkg;

    localparam int unsigned CLK_HZ            = 32'd100_000_000;
    localparam int unsigned DEF_LONG_CYCLES   = CLK_HZ / 32'd2;
    localparam int unsigned DEF_REPEAT_CYCLES = CLK_HZ / 32'd10;
    localparam int unsigned DEF_DCLICK_CYCLES = CLK_HZ / 32'd8;
    localparam int unsigned DEF_CNT_W         = 32'd27;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_LONG   = 3'd2,
        ST_GAP    = 3'd3,
        ST_PRESS2 = 3'd4
    } state_t;

    function automatic logic is_held(input state_t s);
        return (s == ST_PRESS1) || (s == ST_PRESS2) || (s == ST_LONG);
    endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Debounced button level in, gesture pulses out.
interface button_event_decoder_if;

    logic level_in;
    logic press_pulse;
    logic release_pulse;
    logic click_pulse;
    logic double_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    modport slave (
        input  level_in,
        output press_pulse, release_pulse, click_pulse, double_pulse,
               long_pulse, repeat_pulse, held
    );

    modport master (
        output level_in,
        input  press_pulse, release_pulse, click_pulse, double_pulse,
               long_pulse, repeat_pulse, held
    );

endinterface

// File: rtl/button_event_decoder_event_timer.sv
// Shared up-counter with synchronous clear and a terminal-count compare
// against a run-time limit, so one counter serves all gesture phases.
module event_timer #(
    parameter int unsigned CNT_W = 32'd27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    // Count register: clear wins over enable, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_done = (r_count == i_limit);

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle press/release/click/
// double/long/repeat events plus a registered held flag.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned DCLICK_CYCLES = DEF_DCLICK_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    button_event_decoder_if.slave bus
);

    localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(LONG_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] DCLICK_LIM = CNT_W'(DCLICK_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] REP_LIM    =
        CNT_W'((REPEAT_CYCLES == 32'd0) ? 32'd0 : (REPEAT_CYCLES - 32'd1));
    localparam logic             REP_EN     = (REPEAT_CYCLES != 32'd0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_level_q;
    logic             w_rise;
    logic             w_fall;
    logic             w_tmr_clear;
    logic             w_tmr_en;
    logic             w_tmr_done;
    logic [CNT_W-1:0] w_limit;

    logic w_press_nxt, w_release_nxt, w_click_nxt, w_double_nxt;
    logic w_long_nxt, w_repeat_nxt;
    logic r_press, r_release, r_click, r_double, r_long, r_repeat, r_held;

    assign w_rise = bus.level_in & ~r_level_q;
    assign w_fall = ~bus.level_in & r_level_q;

    event_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_tmr_clear),
        .i_enable (w_tmr_en),
        .i_limit  (w_limit),
        .o_done   (w_tmr_done)
    );

    // Terminal count for the phase the FSM is currently timing.
    always_comb begin
        w_limit = LONG_LIM;
        case (r_state)
            ST_PRESS1, ST_PRESS2: w_limit = LONG_LIM;
            ST_LONG:              w_limit = REP_LIM;
            ST_GAP:               w_limit = DCLICK_LIM;
            default:              w_limit = LONG_LIM;
        endcase
    end

    // Next-state and pulse decode; level edges are tested before timer expiry.
    always_comb begin
        w_state_nxt   = r_state;
        w_tmr_clear   = 1'b0;
        w_tmr_en      = 1'b0;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_click_nxt   = 1'b0;
        w_double_nxt  = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tmr_clear = 1'b1;
                if (w_rise) begin
                    w_press_nxt = 1'b1;
                    w_state_nxt = ST_PRESS1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PRESS1, ST_PRESS2: begin
                if (w_fall) begin
                    w_release_nxt = 1'b1;
                    w_tmr_clear   = 1'b1;
                    w_state_nxt   = (r_state == ST_PRESS1) ? ST_GAP : ST_IDLE;
                end else if (w_tmr_done) begin
                    w_long_nxt  = 1'b1;
                    w_tmr_clear = 1'b1;
                    w_state_nxt = ST_LONG;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_LONG: begin
                if (w_fall) begin
                    w_release_nxt = 1'b1;
                    w_tmr_clear   = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (REP_EN && w_tmr_done) begin
                    w_repeat_nxt = 1'b1;
                    w_tmr_clear  = 1'b1;
                end else begin
                    // With repeat disabled the timer is parked to avoid wrapping.
                    w_tmr_en = REP_EN;
                end
            end
            ST_GAP: begin
                if (w_rise) begin
                    w_press_nxt  = 1'b1;
                    w_double_nxt = 1'b1;
                    w_tmr_clear  = 1'b1;
                    w_state_nxt  = ST_PRESS2;
                end else if (w_tmr_done) begin
                    w_click_nxt = 1'b1;
                    w_tmr_clear = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            default: begin
                w_tmr_clear = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and previous-level registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_level_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_level_q <= bus.level_in;
        end
    end

    // Registered event outputs, one clock after the sampling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_click   <= 1'b0;
            r_double  <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_click   <= w_click_nxt;
            r_double  <= w_double_nxt;
            r_long    <= w_long_nxt;
            r_repeat  <= w_repeat_nxt;
            r_held    <= is_held(w_state_nxt);
        end
    end

    assign bus.press_pulse   = r_press;
    assign bus.release_pulse = r_release;
    assign bus.click_pulse   = r_click;
    assign bus.double_pulse  = r_double;
    assign bus.long_pulse    = r_long;
    assign bus.repeat_pulse  = r_repeat;
    assign bus.held          = r_held;

endmodule

// File: tb/tb_button_event_decoder.sv
// Randomized and directed bench for button_event_decoder; two instances
// (repeat enabled / disabled) are checked against a gesture-level model.
module tb_button_event_decoder;

    localparam int L = 8;
    localparam int R = 4;
    localparam int D = 5;
    localparam int W = 8;

    typedef struct {
        int         edge_no;
        logic [6:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic level = 1'b0;
    int   checks = 0;
    int   failures = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea;
    exp_t eb;

    // Model state per instance: 0 = repeat enabled, 1 = repeat disabled.
    int   n_edge[2];
    int   press_t[2];
    int   rel_t[2];
    bit   long_done[2];
    bit   second[2];
    logic prev[2];

    always #5 clk = ~clk;

    button_event_decoder_if bus_a ();
    button_event_decoder_if bus_b ();

    assign bus_a.level_in = level;
    assign bus_b.level_in = level;

    button_event_decoder #(
        .LONG_CYCLES(L), .REPEAT_CYCLES(R), .DCLICK_CYCLES(D), .CNT_W(W)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );

    button_event_decoder #(
        .LONG_CYCLES(L), .REPEAT_CYCLES(0), .DCLICK_CYCLES(D), .CNT_W(W)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    function automatic logic [6:0] got_a();
        return {bus_a.press_pulse, bus_a.release_pulse, bus_a.click_pulse,
                bus_a.double_pulse, bus_a.long_pulse, bus_a.repeat_pulse, bus_a.held};
    endfunction

    function automatic logic [6:0] got_b();
        return {bus_b.press_pulse, bus_b.release_pulse, bus_b.click_pulse,
                bus_b.double_pulse, bus_b.long_pulse, bus_b.repeat_pulse, bus_b.held};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            press_t[i]   = 0;
            rel_t[i]     = -1;
            long_done[i] = 1'b0;
            second[i]    = 1'b0;
            prev[i]      = 1'b0;
        end
    endtask

    // Gesture rules: bits {press, release, click, double, long, repeat, held}.
    function automatic logic [6:0] model_step(input int i, input int rep, input logic l);
        logic [6:0] v;
        int         t;
        v = 7'b0;
        n_edge[i] = n_edge[i] + 1;
        if (l && !prev[i]) begin
            v[6] = 1'b1;
            if (rel_t[i] >= 0) begin
                v[3] = 1'b1;
                second[i] = 1'b1;
            end else begin
                second[i] = 1'b0;
            end
            rel_t[i]     = -1;
            press_t[i]   = n_edge[i];
            long_done[i] = 1'b0;
        end else if (!l && prev[i]) begin
            v[5] = 1'b1;
            if (!long_done[i] && !second[i]) rel_t[i] = n_edge[i];
        end else if (l) begin
            t = n_edge[i] - press_t[i];
            if (t == L) begin
                v[2] = 1'b1;
                long_done[i] = 1'b1;
            end else if (long_done[i] && rep != 0 && t > L && ((t - L) % rep) == 0) begin
                v[1] = 1'b1;
            end
        end else if (rel_t[i] >= 0 && (n_edge[i] - rel_t[i]) == D) begin
            v[4] = 1'b1;
            rel_t[i] = -1;
        end
        v[0] = l;
        prev[i] = l;
        return v;
    endfunction

    task automatic check_vec(input string name, input logic [6:0] got,
                             input logic [6:0] exp, input int edge_no);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%b exp=%b (press,rel,click,dbl,long,rep,held)",
                     name, edge_no, got, exp);
        end
    endtask

    // Set the level for the coming edge and queue what both instances must show.
    task automatic push_step(input logic l);
        exp_t e;
        level = l;
        e.edge_no = n_edge[0] + 1;
        e.v = model_step(0, R, l);
        q_a.push_back(e);
        e.edge_no = n_edge[1] + 1;
        e.v = model_step(1, 0, l);
        q_b.push_back(e);
    endtask

    task automatic hold(input logic l, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            push_step(l);
        end
    endtask

    // Monitor: compare each presented output vector with the queued expectation.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            if (q_a.size() > 0) begin
                ea = q_a.pop_front();
                check_vec("dutA", got_a(), ea.v, ea.edge_no);
            end
            if (q_b.size() > 0) begin
                eb = q_b.pop_front();
                check_vec("dutB_norep", got_b(), eb.v, eb.edge_no);
            end
        end
    end

    initial begin
        n_edge[0] = 0;
        n_edge[1] = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_vec("reset_state_A", got_a(), 7'b0, 0);
        check_vec("reset_state_B", got_b(), 7'b0, 0);
        @(negedge clk);
        reset = 1'b1;
        push_step(1'b0);
        hold(1'b0, 4);

        // Short click, double-click, gap boundary, click boundary, long hold.
        hold(1'b1, 3); hold(1'b0, 10);
        hold(1'b1, 3); hold(1'b0, 2); hold(1'b1, 3); hold(1'b0, 10);
        hold(1'b1, 3); hold(1'b0, D); hold(1'b1, 3); hold(1'b0, 10);
        hold(1'b1, 3); hold(1'b0, D + 1); hold(1'b1, 3); hold(1'b0, 10);
        hold(1'b1, 20); hold(1'b0, 5);
        hold(1'b1, 30); hold(1'b0, 5);

        // Random bursts of alternating level.
        for (int b = 0; b < 80; b++) begin
            hold(b[0] ? 1'b0 : 1'b1, int'($urandom_range(1, 22)));
        end
        hold(1'b0, 12);

        // Asynchronous reset while in LONG, released with the button still down.
        hold(1'b1, 12);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_vec("async_reset_A", got_a(), 7'b0, n_edge[0]);
        check_vec("async_reset_B", got_b(), 7'b0, n_edge[1]);
        q_a.delete();
        q_b.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        push_step(1'b1);
        hold(1'b1, 13);
        hold(1'b0, 10);

        @(posedge clk);
        #2;
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d/%0d required=0/0", q_a.size(), q_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
